// File: rtl/sopc_mem_arbiter_pkg.sv
// sopc_mem_arbiter_pkg: shared state/grant encodings and wait-counter width for the memory arbiter
package sopc_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable down-counter with zero flag that times the memory wait states
module mem_wait_cnt
  import sopc_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: shares one wait-stated memory port between CPU fetch and load/store channels
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int WAIT_CYCLES = 1,
  parameter int FAIR        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_ce,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_o
);
  state_e state_q, state_d;
  gnt_e gnt_q, gnt_d, last_q, last_d;
  logic m_ce_q, m_ce_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [SEL_W-1:0] m_sel_q, m_sel_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic can_i, can_d, win_d, cnt_load, cnt_dec, cnt_zero;
  mem_wait_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );
  // From DONE only the channel that was not just acked may be granted
  always_comb begin
    can_i = i_req && (state_q == IDLE || (state_q == DONE && gnt_q == GNT_D));
    can_d = d_req && (state_q == IDLE || (state_q == DONE && gnt_q == GNT_I));
    win_d = can_d && (!can_i || FAIR == 0 || last_q == GNT_I);
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    m_ce_d = m_ce_q;
    m_we_d = m_we_q;
    m_addr_d = m_addr_q;
    m_sel_d = m_sel_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load = 1'b0;
    cnt_dec = 1'b0;
    if (can_i || can_d) begin
      state_d = WAIT;
      gnt_d = win_d ? GNT_D : GNT_I;
      last_d = gnt_d;
      m_ce_d = 1'b1;
      m_we_d = win_d && d_we;
      m_addr_d = win_d ? d_addr : i_addr;
      m_sel_d = win_d ? d_sel : '1;
      m_wdata_d = win_d ? d_wdata : m_wdata_q;
      cnt_load = 1'b1;
    end else if (state_q == WAIT) begin
      cnt_dec = !cnt_zero;
      if (cnt_zero) begin
        state_d = DONE;
        m_ce_d = 1'b0;
        m_we_d = 1'b0;
        i_rdata_d = gnt_q == GNT_I ? m_rdata : i_rdata_q;
        d_rdata_d = (gnt_q == GNT_D && !m_we_q) ? m_rdata : d_rdata_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= GNT_I;
      last_q <= GNT_I;
      m_ce_q <= 1'b0;
      m_we_q <= 1'b0;
      m_addr_q <= '0;
      m_sel_q <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      m_ce_q <= m_ce_d;
      m_we_q <= m_we_d;
      m_addr_q <= m_addr_d;
      m_sel_q <= m_sel_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign i_ack = state_q == DONE && gnt_q == GNT_I;
  assign d_ack = state_q == DONE && gnt_q == GNT_D;
  assign m_ce = m_ce_q;
  assign m_we = m_we_q;
  assign m_addr = m_addr_q;
  assign m_sel = m_sel_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall_o = (i_req && !i_ack) || (d_req && !d_ack);
endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// tb_sopc_mem_arbiter: three arbiter configurations against wait-stated memories and a transaction-level model
module tb_sopc_mem_arbiter;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0] i_req, i_ack, d_req, d_we, d_ack, m_ce, m_we, stall;
  logic [NI-1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [NI-1:0][3:0] d_sel, m_sel;
  logic [31:0] smem [NI][64];
  int mcnt [NI];
  bit inited = 1'b0;
  int checks = 0;
  int failures = 0;
  bit busy, ec, last_d, t_we;
  int exp_t, free_t;
  logic [31:0] t_addr, t_wdata, exp_ir, exp_dr;
  logic [3:0] t_sel;
  logic [31:0] refm [64];

  function automatic int wcfg(int g);
    return g == 0 ? 2 : g == 1 ? 0 : 5;
  endfunction
  function automatic int fcfg(int g);
    return g == 0 ? 0 : 1;
  endfunction
  function automatic logic [31:0] init_val(int a);
    return a == 4 ? 32'h3401_0020 : a == 8 ? 32'h0 : a == 9 ? 32'h1122_3344 : {8'hA5, 8'(a), 16'(a * 977)};
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sopc_mem_arbiter #(.WAIT_CYCLES(wcfg(g)), .FAIR(fcfg(g))) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req[g]),
      .i_addr  (i_addr[g]),
      .i_rdata (i_rdata[g]),
      .i_ack   (i_ack[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_sel   (d_sel[g]),
      .d_wdata (d_wdata[g]),
      .d_rdata (d_rdata[g]),
      .d_ack   (d_ack[g]),
      .m_ce    (m_ce[g]),
      .m_we    (m_we[g]),
      .m_addr  (m_addr[g]),
      .m_sel   (m_sel[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g]),
      .stall_o (stall[g])
    );
    assign m_rdata[g] = smem[g][m_addr[g][7:2]];
  end

  // Memory commits a write only once m_ce has been held for its full wait-state count
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      for (int a = 0; a < 64; a++) if (!inited) smem[g][a] <= init_val(a);
      if (inited && m_ce[g]) begin
        if (mcnt[g] == wcfg(g) && m_we[g])
          for (int b = 0; b < 4; b++) if (m_sel[g][b]) smem[g][m_addr[g][7:2]][8*b +: 8] <= m_wdata[g][8*b +: 8];
        mcnt[g] <= mcnt[g] + 1;
      end else mcnt[g] <= 0;
    end
    inited <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = '0;
    d_req = '0;
    d_we = '0;
    i_addr = '0;
    d_addr = '0;
    d_sel = '0;
    d_wdata = '0;
  endtask

  task automatic wait_ack(input int g, input bit dch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dch ? d_ack[g] : i_ack[g]) && n < 40);
  endtask

  task automatic grant(input int g, input bit c, input int n);
    busy = 1'b1;
    ec = c;
    exp_t = n + wcfg(g) + 2;
    last_d = c;
    t_addr = c ? d_addr[g] : i_addr[g];
    t_we = c && d_we[g];
    t_sel = c ? d_sel[g] : 4'hF;
    t_wdata = d_wdata[g];
  endtask

  // Single-server model: each access occupies W+1 memory cycles, then one ack cycle
  task automatic run_random(input int g, input int cycles);
    bit ea_i, ea_d, own_i, own_d;
    int idx;
    busy = 1'b0;
    free_t = 0;
    last_d = 1'b0;
    exp_ir = '0;
    exp_dr = '0;
    for (int a = 0; a < 64; a++) refm[a] = init_val(a);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      ea_i = busy && n == exp_t && !ec;
      ea_d = busy && n == exp_t && ec;
      idx = int'(t_addr[7:2]);
      chk("r_iack", i_ack[g], ea_i);
      chk("r_dack", d_ack[g], ea_d);
      chk("r_ce", m_ce[g], busy && n < exp_t);
      chk("r_stall", stall[g], (i_req[g] && !ea_i) || (d_req[g] && !ea_d));
      if (busy && n < exp_t) begin
        chk("r_addr", m_addr[g], t_addr);
        chk("r_we", m_we[g], t_we);
        chk("r_sel", m_sel[g], t_sel);
        if (t_we) chk("r_wdata", m_wdata[g], t_wdata);
      end
      if (ea_i) exp_ir = refm[idx];
      if (ea_d && !t_we) exp_dr = refm[idx];
      if (ea_d && t_we)
        for (int b = 0; b < 4; b++) if (t_sel[b]) refm[idx][8*b +: 8] = t_wdata[8*b +: 8];
      chk("r_irdata", i_rdata[g], exp_ir);
      chk("r_drdata", d_rdata[g], exp_dr);
      if (ea_i) i_req[g] = 1'b0;
      if (ea_d) d_req[g] = 1'b0;
      own_i = busy && !ec && n < exp_t;
      own_d = busy && ec && n < exp_t;
      if (own_i && i_req[g] && $urandom_range(7) == 0) i_req[g] = 1'b0;
      if (own_d && d_req[g] && $urandom_range(7) == 0) d_req[g] = 1'b0;
      if (!i_req[g] && !own_i && $urandom_range(2) == 0) begin
        i_addr[g] = {24'h0, 6'($urandom_range(63, 16)), 2'b00};
        i_req[g] = 1'b1;
      end
      if (!d_req[g] && !own_d && $urandom_range(2) == 0) begin
        d_addr[g] = {24'h0, 6'($urandom_range(63, 16)), 2'b00};
        d_we[g] = 1'($urandom_range(1));
        d_sel[g] = $urandom_range(7) == 0 ? 4'h0 : 4'($urandom);
        d_wdata[g] = $urandom;
        d_req[g] = 1'b1;
      end
      if (busy && n == exp_t) begin
        busy = 1'b0;
        free_t = n + 1;
        if (ec ? i_req[g] : d_req[g]) grant(g, !ec, n);
      end else if (!busy && n >= free_t && (i_req[g] || d_req[g])) begin
        grant(g, (i_req[g] && d_req[g]) ? (fcfg(g) == 0 || !last_d) : d_req[g], n);
      end
    end
  endtask

  initial begin
    int n, pulses, at;
    idle_inputs();
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_ce", m_ce[g], 0);
      chk("rst_we", m_we[g], 0);
      chk("rst_addr", m_addr[g], 0);
      chk("rst_sel", m_sel[g], 0);
      chk("rst_wdata", m_wdata[g], 0);
      chk("rst_iack", i_ack[g], 0);
      chk("rst_dack", d_ack[g], 0);
      chk("rst_irdata", i_rdata[g], 0);
      chk("rst_drdata", d_rdata[g], 0);
      chk("rst_stall", stall[g], 0);
    end
    rst = 1'b1;
    @(negedge clk);
    // fetch read, W=2
    i_addr[0] = 32'h10;
    i_req[0] = 1'b1;
    #1 chk("t1_stall", stall[0], 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_ce", m_ce[0], k <= 3);
      chk("t1_iack", i_ack[0], k == 4);
      if (k <= 3) begin
        chk("t1_addr", m_addr[0], 32'h10);
        chk("t1_sel", m_sel[0], 4'hF);
        chk("t1_we", m_we[0], 0);
      end
    end
    chk("t1_rdata", i_rdata[0], 32'h3401_0020);
    i_req[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_once", i_ack[0], 0);
    chk("t1_hold", i_rdata[0], 32'h3401_0020);
    // round-robin, W=0, both channels held high
    d_addr[1] = 32'h40;
    d_sel[1] = 4'hF;
    d_we[1] = 1'b0;
    d_req[1] = 1'b1;
    i_addr[1] = 32'h44;
    i_req[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t5_ce", m_ce[1], k % 2 == 1);
      chk("t5_dack", d_ack[1], k == 2 || k == 6);
      chk("t5_iack", i_ack[1], k == 4 || k == 8);
    end
    chk("t5_drdata", d_rdata[1], init_val(16));
    chk("t5_irdata", i_rdata[1], init_val(17));
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
    @(negedge clk);
    // byte store then load, W=0
    d_addr[1] = 32'h20;
    d_we[1] = 1'b1;
    d_sel[1] = 4'b0010;
    d_wdata[1] = 32'h0000_AB00;
    d_req[1] = 1'b1;
    wait_ack(1, 1'b1, n);
    chk("t3_st_lat", n, 2);
    chk("t3_st_hold", d_rdata[1], init_val(16));
    d_req[1] = 1'b0;
    @(negedge clk);
    d_we[1] = 1'b0;
    d_sel[1] = 4'hF;
    d_req[1] = 1'b1;
    wait_ack(1, 1'b1, n);
    chk("t3_ld_lat", n, 2);
    chk("t3_ld_data", d_rdata[1], 32'h0000_AB00);
    d_req[1] = 1'b0;
    @(negedge clk);
    // simultaneous requests, fixed priority, W=2
    i_addr[0] = 32'h48;
    d_addr[0] = 32'h4C;
    d_we[0] = 1'b0;
    d_sel[0] = 4'hF;
    i_req[0] = 1'b1;
    d_req[0] = 1'b1;
    wait_ack(0, 1'b1, n);
    chk("t4_d_first", n, 4);
    chk("t4_i_wait", i_ack[0], 0);
    chk("t4_drdata", d_rdata[0], init_val(19));
    d_req[0] = 1'b0;
    wait_ack(0, 1'b0, n);
    chk("t4_i_chain", n, 4);
    chk("t4_irdata", i_rdata[0], init_val(18));
    i_req[0] = 1'b0;
    @(negedge clk);
    // reset in the third wait cycle of a store, W=5
    d_addr[2] = 32'h24;
    d_we[2] = 1'b1;
    d_sel[2] = 4'hF;
    d_wdata[2] = 32'hDEAD_BEEF;
    d_req[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ce", m_ce[2], 1);
    chk("t6_we", m_we[2], 1);
    #1 rst = 1'b0;
    #1 chk("t6_ce_rst", m_ce[2], 0);
    chk("t6_we_rst", m_we[2], 0);
    d_req[2] = 1'b0;
    d_we[2] = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      pulses += int'(d_ack[2]);
    end
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(d_ack[2]);
      chk("t6_idle", m_ce[2], 0);
    end
    chk("t6_no_ack", pulses, 0);
    i_addr[2] = 32'h24;
    i_req[2] = 1'b1;
    wait_ack(2, 1'b0, n);
    chk("t6_lat", n, 7);
    chk("t6_unchanged", i_rdata[2], 32'h1122_3344);
    i_req[2] = 1'b0;
    @(negedge clk);
    // data request dropped during wait, W=5
    d_addr[2] = 32'h28;
    d_sel[2] = 4'hF;
    d_req[2] = 1'b1;
    @(negedge clk);
    chk("t7_stall", stall[2], 1);
    @(negedge clk);
    d_req[2] = 1'b0;
    #1 chk("t7_stall_drop", stall[2], 0);
    pulses = 0;
    at = 0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (d_ack[2]) begin
        pulses++;
        at = k;
      end
    end
    chk("t7_pulses", pulses, 1);
    chk("t7_at", at, 7);
    chk("t7_rdata", d_rdata[2], init_val(10));
    for (int g = 0; g < NI; g++) begin
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_random(g, 600);
    end
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
